// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush controller for the 5-stage pipeline: thermometer stall vector, branch flush, multi-cycle EX tracking.
// Outputs are combinational from registered FSM state and current inputs; stall/flush performance counters are registered.
module pipeline_hazard_ctrl #(
    parameter int MULTI_CYCLES = 4,
    parameter int CNT_W        = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic        id_uses_rs1,
    input  logic        id_uses_rs2,
    input  logic [4:0]  ex_rd,
    input  logic        ex_is_load,
    input  logic        ex_multi_start,
    input  logic        ex_br_taken,
    input  logic        mem_req,
    input  logic        mem_ready,
    output logic [4:0]  stall,
    output logic        br,
    output logic        ex_done,
    output logic        state,
    output logic [31:0] stall_cycles,
    output logic [15:0] flush_count
);

    typedef enum logic {RUN = 1'b0, MULTI = 1'b1} state_t;

    localparam logic [4:0] STALL_NONE = 5'b00000;
    localparam logic [4:0] STALL_LU   = 5'b00011;
    localparam logic [4:0] STALL_EX   = 5'b00111;
    localparam logic [4:0] STALL_MEM  = 5'b01111;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             memw;
    logic             load_use;

    assign memw = mem_req & ~mem_ready;

    assign load_use = ex_is_load && (ex_rd != 5'd0) &&
                      ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                       (id_uses_rs2 && (id_rs2 == ex_rd)));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stall   = STALL_NONE;
        br      = 1'b0;
        ex_done = 1'b0;

        // The counter keeps running under memw: the EX unit computes regardless of the freeze.
        if (state_q == MULTI && cnt_q != '0)
            cnt_d = cnt_q - 1'b1;

        if (memw) begin
            stall = STALL_MEM;
        end else if (state_q == MULTI) begin
            if (cnt_q != '0) begin
                stall = STALL_EX;
            end else begin
                ex_done = 1'b1;
                state_d = RUN;
                br      = ex_br_taken;
            end
        end else if (ex_multi_start) begin
            // A simultaneous taken branch is illegal; the multi-cycle op wins.
            stall   = STALL_EX;
            state_d = MULTI;
            cnt_d   = CNT_W'(MULTI_CYCLES - 2);
        end else if (ex_br_taken) begin
            br = 1'b1;
        end else if (load_use) begin
            stall = STALL_LU;
        end

        if (reset) begin
            stall   = STALL_NONE;
            br      = 1'b0;
            ex_done = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= RUN;
            cnt_q        <= '0;
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (stall[0])
                stall_cycles <= stall_cycles + 32'd1;
            if (br)
                flush_count <= flush_count + 16'd1;
        end
    end

    assign state = state_q;

endmodule
